// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the canonical nop encoding and the IF/ID hazard action set.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [2:0] {
        ACT_FLUSH_EXC,
        ACT_STALL,
        ACT_FLUSH,
        ACT_FETCH_WAIT,
        ACT_ADVANCE
    } action_t;

endpackage

// File: rtl/if_id_hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline register with stall/flush control, PC write-enable, ID/EX bubble,
// saturating perf counters and a consecutive-stall watchdog.
module if_id_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             DataHazard,
    input  logic             ControlHazard,
    input  logic             Exception,
    input  logic             imem_ready,
    input  logic [31:0]      if_pc_plus4,
    input  logic [31:0]      if_instruction,
    output logic             pc_write_en,
    output logic             if_id_valid,
    output logic [31:0]      if_id_pc_plus4,
    output logic [31:0]      if_id_instr,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_timeout
);

    localparam int              RUN_W     = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL + 1);

    action_t          w_act;
    logic [RUN_W-1:0] w_run_next;
    logic             r_valid;
    logic [31:0]      r_instr;
    logic [31:0]      r_pc4;
    logic [RUN_W-1:0] r_run;
    logic             r_timeout;

    // Exception outranks a stall so a trap is never lost behind an operand wait.
    always_comb begin
        if (Exception)          w_act = ACT_FLUSH_EXC;
        else if (DataHazard)    w_act = ACT_STALL;
        else if (ControlHazard) w_act = ACT_FLUSH;
        else if (!imem_ready)   w_act = ACT_FETCH_WAIT;
        else                    w_act = ACT_ADVANCE;
    end

    always_comb begin
        pc_write_en  = 1'b0;
        id_ex_bubble = 1'b0;
        case (w_act)
            ACT_FLUSH_EXC: begin
                pc_write_en  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            ACT_STALL:      id_ex_bubble = 1'b1;
            ACT_FLUSH:      pc_write_en  = 1'b1;
            ACT_FETCH_WAIT: pc_write_en  = 1'b0;
            default:        pc_write_en  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
        end else if (w_act == ACT_ADVANCE) begin
            r_valid <= 1'b1;
            r_instr <= if_instruction;
            r_pc4   <= if_pc_plus4;
        end else if (w_act != ACT_STALL) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
        end
    end

    // Timeout looks at the post-edge run length so it rises on the edge that exceeds the limit.
    assign w_run_next = (w_act != ACT_STALL) ? '0 :
                        (r_run == RUN_LIMIT) ? r_run : r_run + RUN_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_run     <= w_run_next;
            r_timeout <= r_timeout | (w_run_next == RUN_LIMIT);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_act == ACT_STALL),
        .count   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     ((w_act == ACT_FLUSH_EXC) || (w_act == ACT_FLUSH)),
        .count   (flush_cnt)
    );

    assign if_id_valid    = r_valid;
    assign if_id_instr    = r_instr;
    assign if_id_pc_plus4 = r_pc4;
    assign stall_timeout  = r_timeout;

endmodule
